// File: rtl/trap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// trap_ctrl_pkg : shared cause codes, FSM encodings and CLINT register offsets
// Revision: 1.0
// ============================================================================
package trap_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_TRAP     = 2'd1,
      ST_REDIRECT = 2'd2
   } trap_state_t;

   localparam logic [63:0] c_cause_illegal_instr = 64'd2;
   localparam logic [63:0] c_cause_ecall_u       = 64'd8;
   localparam logic [63:0] c_cause_ecall_m       = 64'd11;
   localparam logic [63:0] c_int_mtimer          = 64'h8000_0000_0000_0007;

   localparam logic [15:0] c_off_mtimecmp = 16'h4000;
   localparam logic [15:0] c_off_mtime    = 16'hBFF8;

   localparam logic [1:0]  c_priv_m = 2'b11;

endpackage
`default_nettype wire

// File: rtl/clint_timer.sv
`default_nettype none
// ============================================================================
// clint_timer : mtime/mtimecmp registers, prescaler, MMIO decode, mtip
// Revision: 1.0
// ============================================================================
module clint_timer
   import trap_ctrl_pkg::*;
#(
   parameter int          TIMER_DIV  = 1,
   parameter logic [63:0] CLINT_BASE = 64'h0200_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        mmio_sel_i,
   input  logic        mmio_wen_i,
   input  logic [63:0] mmio_addr_i,
   input  logic [63:0] mmio_wdata_i,
   output logic [63:0] mmio_rdata_o,
   output logic [63:0] mtime_o,
   output logic        mtip_o
);

   localparam int              DIV_W       = (TIMER_DIV > 1) ? $clog2(TIMER_DIV) : 1;
   localparam logic [DIV_W-1:0] c_div_last = DIV_W'(TIMER_DIV - 1);
   localparam logic [63:0]     c_addr_cmp  = CLINT_BASE + {48'd0, c_off_mtimecmp};
   localparam logic [63:0]     c_addr_time = CLINT_BASE + {48'd0, c_off_mtime};

   logic [63:0]      r_mtime;
   logic [63:0]      r_mtimecmp;
   logic [DIV_W-1:0] r_div;
   logic             r_mtip;
   logic             w_hit_cmp;
   logic             w_hit_time;
   logic [63:0]      w_rdata;

   assign w_hit_cmp  = mmio_sel_i && (mmio_addr_i == c_addr_cmp);
   assign w_hit_time = mmio_sel_i && (mmio_addr_i == c_addr_time);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_mtime    <= '0;
         r_mtimecmp <= '1;
         r_div      <= '0;
         r_mtip     <= 1'b0;
      end else begin
         r_mtip <= (r_mtime >= r_mtimecmp);
         // A software write to mtime replaces the tick and restarts the prescaler
         if (w_hit_time && mmio_wen_i) begin
            r_mtime <= mmio_wdata_i;
            r_div   <= '0;
         end else if (r_div == c_div_last) begin
            r_mtime <= r_mtime + 64'd1;
            r_div   <= '0;
         end else begin
            r_div <= r_div + 1'b1;
         end
         if (w_hit_cmp && mmio_wen_i) begin
            r_mtimecmp <= mmio_wdata_i;
         end
      end
   end

   always_comb begin
      w_rdata = '0;
      if (w_hit_cmp) begin
         w_rdata = r_mtimecmp;
      end else if (w_hit_time) begin
         w_rdata = r_mtime;
      end
   end

   assign mmio_rdata_o = w_rdata;
   assign mtime_o      = r_mtime;
   assign mtip_o       = r_mtip;

endmodule
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// trap_ctrl : WB trap arbitration, CSRFile handshake and IF redirect sequencing
// Revision: 1.0
// ============================================================================
module trap_ctrl
   import trap_ctrl_pkg::*;
#(
   parameter int          TIMER_DIV  = 1,
   parameter logic [63:0] CLINT_BASE = 64'h0200_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        wb_valid_i,
   input  logic [63:0] wb_pc_i,
   input  logic        wb_exc_i,
   input  logic [63:0] wb_cause_i,
   input  logic [1:0]  priv_i,
   input  logic        mstatus_mie_i,
   input  logic        mie_mtie_i,
   input  logic [63:0] csr_newpc_i,
   input  logic        mmio_sel_i,
   input  logic        mmio_wen_i,
   input  logic [63:0] mmio_addr_i,
   input  logic [63:0] mmio_wdata_i,
   output logic [63:0] mmio_rdata_o,
   output logic        wb_kill_o,
   output logic        exception_o,
   output logic [63:0] cause_o,
   output logic [63:0] pc_o,
   output logic        flush_o,
   output logic        redirect_valid_o,
   output logic [63:0] redirect_pc_o,
   output logic        mtip_o,
   output logic [63:0] mtime_o
);

   trap_state_t r_state;
   logic        r_exception;
   logic        r_flush;
   logic        r_redirect_valid;
   logic [63:0] r_cause;
   logic [63:0] r_pc;
   logic [63:0] r_redirect_pc;
   logic        w_mtip;
   logic [63:0] w_mtime;
   logic        w_irq_en;
   logic        w_accept;

   clint_timer #(
      .TIMER_DIV  (TIMER_DIV),
      .CLINT_BASE (CLINT_BASE)
   ) u_clint_timer (
      .clock        (clock),
      .reset        (reset),
      .mmio_sel_i   (mmio_sel_i),
      .mmio_wen_i   (mmio_wen_i),
      .mmio_addr_i  (mmio_addr_i),
      .mmio_wdata_i (mmio_wdata_i),
      .mmio_rdata_o (mmio_rdata_o),
      .mtime_o      (w_mtime),
      .mtip_o       (w_mtip)
   );

   assign w_irq_en = mtip_o && mie_mtie_i && ((priv_i < c_priv_m) || mstatus_mie_i);
   assign w_accept = (r_state == ST_IDLE) && !reset && wb_valid_i && (wb_exc_i || w_irq_en);

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state          <= ST_IDLE;
         r_exception      <= 1'b0;
         r_flush          <= 1'b0;
         r_redirect_valid <= 1'b0;
         r_cause          <= '0;
         r_pc             <= '0;
         r_redirect_pc    <= '0;
      end else begin
         r_exception      <= 1'b0;
         r_flush          <= 1'b0;
         r_redirect_valid <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_accept) begin
                  r_state     <= ST_TRAP;
                  r_exception <= 1'b1;
                  r_flush     <= 1'b1;
                  // Synchronous exceptions win; the interrupt stays pending
                  r_cause     <= wb_exc_i ? wb_cause_i : c_int_mtimer;
                  r_pc        <= wb_pc_i;
               end
            end
            ST_TRAP: begin
               r_state          <= ST_REDIRECT;
               r_flush          <= 1'b1;
               r_redirect_valid <= 1'b1;
               r_redirect_pc    <= csr_newpc_i;
            end
            ST_REDIRECT: begin
               r_state <= ST_IDLE;
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   assign wb_kill_o        = w_accept;
   assign exception_o      = r_exception && !reset;
   assign cause_o          = exception_o ? r_cause : '0;
   assign pc_o             = exception_o ? r_pc : '0;
   assign flush_o          = r_flush && !reset;
   assign redirect_valid_o = r_redirect_valid && !reset;
   assign redirect_pc_o    = reset ? '0 : r_redirect_pc;
   assign mtip_o           = w_mtip && !reset;
   assign mtime_o          = reset ? '0 : w_mtime;

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameter TIMER_DIV, default 1, meaning core cycles per mtime increment (legal values are 1 or greater).
REQ-002 SHALL have parameter CLINT_BASE, default 64'h0200_0000, meaning the base address of the mtimecmp/mtime MMIO window.
REQ-003 SHALL have ports, in this order:
- clock  in  1  single clock; one clock domain; reset is synchronous and active-high.
- reset  in  1  synchronous, active-high.
- wb_valid_i  in  1  a valid instruction is present in WB.
- wb_pc_i  in  64  PC of the WB instruction.
- wb_exc_i  in  1  the WB instruction raised a synchronous trap or xRET.
- wb_cause_i  in  64  cause of that trap (define.v codes).
- priv_i  in  2  current privilege level from CSRFile.
- mstatus_mie_i  in  1  mstatus.MIE.
- mie_mtie_i  in  1  mie.MTIE.
- csr_newpc_i  in  64  exception target PC from CSRFile.
- mmio_sel_i  in  1  MMIO access strobe.
- mmio_wen_i  in  1  MMIO write enable.
- mmio_addr_i  in  64  MMIO address.
- mmio_wdata_i  in  64  MMIO write data.
- mmio_rdata_o  out  64  MMIO read data.
- wb_kill_o  out  1  suppresses the WB commit of the trapped instruction.
- exception_o  out  1  one-cycle pulse to CSRFile exception_i.
- cause_o  out  64  to CSRFile cause_i.
- pc_o  out  64  to CSRFile pc_i.
- flush_o  out  1  flushes all pipeline stages.
- redirect_valid_o  out  1  tells IF to load redirect_pc_o.
- redirect_pc_o  out  64  trap target PC.
- mtip_o  out  1  machine timer interrupt pending.
- mtime_o  out  64  current mtime value.

Function
REQ-004 SHALL implement a three-state FSM with states IDLE, TRAP and REDIRECT.
REQ-005 SHALL accept a trap in IDLE when wb_valid_i=1 and either wb_exc_i=1 or an interrupt is enabled; the FSM then goes to TRAP on the next edge.
REQ-006 SHALL treat an interrupt as enabled when mtip_o=1, mie_mtie_i=1, and either priv_i is below M or mstatus_mie_i=1.
REQ-007 SHALL give a synchronous exception priority over an interrupt in the same cycle; the interrupt remains pending.
REQ-008 SHALL drive wb_kill_o combinationally in the accept cycle only.
REQ-009 SHALL latch cause and PC in the accept cycle:
- exception: cause = wb_cause_i, PC = wb_pc_i.
- interrupt: cause = 64'h8000_0000_0000_0007, PC = wb_pc_i.
REQ-010 SHALL, in TRAP, drive exception_o=1, flush_o=1 and the latched cause_o/pc_o, sample csr_newpc_i into redirect_pc_o, and go to REDIRECT.
REQ-011 SHALL, in REDIRECT, drive redirect_valid_o=1 and flush_o=1, then go to IDLE.
REQ-012 SHALL meet these latencies: exception_o 1 cycle after accept; redirect_valid_o 2 cycles after accept; each exactly one cycle wide.
REQ-013 SHALL ignore wb_valid_i and wb_exc_i in TRAP and REDIRECT, so no back-to-back trap is accepted; the next accept is possible in the cycle after REDIRECT.
REQ-014 SHALL drive cause_o and pc_o to 0 whenever exception_o=0.
REQ-015 SHALL increment mtime by 1 every TIMER_DIV cycles, with a divider counter that counts 0..TIMER_DIV-1; mtime wraps from 2^64-1 to 0.
REQ-016 SHALL map mtimecmp at CLINT_BASE+16'h4000 and mtime at CLINT_BASE+16'hBFF8, both full 64-bit, and accessed only when mmio_sel_i=1.
REQ-017 SHALL apply an MMIO write to mtime instead of that cycle's increment and reset the divider to 0.
REQ-018 SHALL register mtip_o = (mtime >= mtimecmp), so it reflects register values of the previous cycle (unsigned compare).
REQ-019 SHALL drive mmio_rdata_o combinationally with the mapped register; unmapped addresses, or mmio_sel_i=0, read as 0; writes to unmapped addresses are dropped.

Reset
REQ-020 SHALL, with reset=1 at an edge, set FSM=IDLE, mtime=0, mtimecmp=all ones, divider=0, mtip_o=0, redirect_pc_o=0 and latched cause/PC=0.
REQ-021 SHALL hold every output at 0 during reset, except mmio_rdata_o, which follows its decode of the reset register values.
REQ-022 SHALL abort a trap in progress when reset is asserted in TRAP or REDIRECT: no further exception_o or redirect_valid_o pulse is issued.

Structure
REQ-023 SHALL take the following constants from shared define.v:
- cause codes, including INT_MTIMER = 64'h8000_0000_0000_0007.
- FSM state encodings.
- the CLINT offsets 16'h4000 and 16'hBFF8.
REQ-024 SHALL place mtime, mtimecmp, the divider, the MMIO decode and mtip in one sub-module, clint_timer; the FSM and arbitration stay in trap_ctrl.

Verification
REQ-025 SHALL cover ecall accept: wb_valid_i=1, wb_exc_i=1, cause 8, pc 64'h8000_0100 and csr_newpc_i 64'h8000_0000 -> wb_kill_o same cycle; exception_o with cause_o=8 and pc_o=64'h8000_0100 at +1; redirect_pc_o=64'h8000_0000 at +2; flush_o at +1 and +2.
REQ-026 SHALL cover the timer interrupt: TIMER_DIV=1, write mtimecmp=10, MIE=1, MTIE=1, priv M -> mtip_o rises when mtime reaches 10; the next valid WB instruction traps with cause 64'h8000_0000_0000_0007.
REQ-027 SHALL cover simultaneous events: exception cause 2 and interrupt pending in the same cycle -> cause_o=2; the interrupt is taken at the first valid WB after REDIRECT.
REQ-028 SHALL cover masking: priv M, MIE=0, mtip_o=1 -> no trap; switching priv_i to U -> a trap on the next valid WB.
REQ-029 SHALL cover timer wrap and MMIO: write mtime=64'hFFFF_FFFF_FFFF_FFFF with TIMER_DIV=4 -> mtime is 0 four cycles later; reading address CLINT_BASE+16'h1000 returns 0.
REQ-030 SHALL cover reset mid-trap: reset asserted in TRAP -> no redirect_valid_o pulse, mtime=0 and mtimecmp=all ones after reset.
